// File: rtl/dcache_write_buffer.sv
// Write-back buffer between the data cache and the 256-bit Data_Memory.
// Queues dirty-line write-backs and coalesces repeats. Reads either forward from the queue or bypass it.
module dcache_write_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  cache_addr_i,
    input  logic [255:0] cache_data_i,
    input  logic         cache_enable_i,
    input  logic         cache_write_i,
    output logic         cache_ack_o,
    output logic [255:0] cache_data_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    input  logic         mem_ack_i,
    input  logic [255:0] mem_data_i,
    output logic         wb_empty_o
);

    typedef enum logic [1:0] {U_IDLE, U_WAIT_RD, U_ACK} u_state_t;
    typedef enum logic [1:0] {D_IDLE, D_READ, D_WRITE} d_state_t;

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    u_state_t         u_state_reg;
    d_state_t         d_state_reg;
    logic [DEPTH-1:0] valid_reg;
    logic [26:0]      tag_reg  [DEPTH];
    logic [255:0]     data_reg [DEPTH];
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [PTR_W:0]   count_reg;
    logic             rd_req_reg;
    logic [26:0]      rd_tag_reg;
    logic             cache_ack_reg;
    logic [255:0]     cache_data_reg;
    logic [31:0]      mem_addr_reg;
    logic [255:0]     mem_data_reg;
    logic             mem_enable_reg;
    logic             mem_write_reg;

    logic [26:0]      req_tag;
    logic [DEPTH-1:0] hit;
    logic [DEPTH-1:0] coal_vec;
    logic             coal_hit;
    logic [PTR_W-1:0] coal_idx;
    logic             fwd_hit;
    logic [PTR_W-1:0] fwd_idx;
    logic [PTR_W-1:0] scan_idx;
    logic             u_req;
    logic             do_push;
    logic             do_coalesce;
    logic             do_pop;
    logic             start_read;
    logic             start_write;
    logic             head_busy;
    logic             rd_done;
    logic             unused_addr_bits;

    assign req_tag          = cache_addr_i[31:5];
    assign unused_addr_bits = ^cache_addr_i[4:0];

    assign u_req       = (u_state_reg == U_IDLE) && cache_enable_i;
    assign start_read  = (d_state_reg == D_IDLE) && rd_req_reg;
    assign start_write = (d_state_reg == D_IDLE) && !rd_req_reg && (count_reg != '0);
    // The head is untouchable both while it drains and on the edge it is launched.
    assign head_busy   = (d_state_reg == D_WRITE) || start_write;
    assign do_pop      = (d_state_reg == D_WRITE) && mem_ack_i;
    assign rd_done     = (d_state_reg == D_READ) && mem_ack_i;
    assign do_coalesce = u_req && cache_write_i && coal_hit;
    assign do_push     = u_req && cache_write_i && !coal_hit && (count_reg != FULL_COUNT);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign hit[gi]      = valid_reg[gi] && (tag_reg[gi] == req_tag);
            assign coal_vec[gi] = hit[gi] && !(head_busy && (PTR_W'(gi) == head_reg));
        end
    endgenerate

    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (coal_vec[k]) begin
                coal_hit = 1'b1;
                coal_idx = PTR_W'(k);
            end
        end
    end

    // Scan oldest to newest so the last hit found is the newest copy.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_idx  = head_reg;
        scan_idx = head_reg;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_reg + PTR_W'(k);
            if (hit[scan_idx]) begin
                fwd_hit = 1'b1;
                fwd_idx = scan_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            tag_reg[tail_reg]  <= req_tag;
            data_reg[tail_reg] <= cache_data_i;
        end else if (do_coalesce) begin
            data_reg[coal_idx] <= cache_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_reg <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (do_push) begin
                valid_reg[tail_reg] <= 1'b1;
                tail_reg            <= tail_reg + PTR_W'(1);
            end
            if (do_pop) begin
                valid_reg[head_reg] <= 1'b0;
                head_reg            <= head_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            u_state_reg    <= U_IDLE;
            cache_ack_reg  <= 1'b0;
            cache_data_reg <= '0;
            rd_req_reg     <= 1'b0;
            rd_tag_reg     <= '0;
        end else begin
            if (start_read) rd_req_reg <= 1'b0;
            case (u_state_reg)
                U_IDLE: begin
                    if (cache_enable_i) begin
                        if (cache_write_i) begin
                            if (coal_hit || (count_reg != FULL_COUNT)) begin
                                cache_ack_reg <= 1'b1;
                                u_state_reg   <= U_ACK;
                            end
                        end else if (fwd_hit) begin
                            cache_data_reg <= data_reg[fwd_idx];
                            cache_ack_reg  <= 1'b1;
                            u_state_reg    <= U_ACK;
                        end else begin
                            rd_req_reg  <= 1'b1;
                            rd_tag_reg  <= req_tag;
                            u_state_reg <= U_WAIT_RD;
                        end
                    end
                end
                U_WAIT_RD: begin
                    if (rd_done) begin
                        cache_data_reg <= mem_data_i;
                        cache_ack_reg  <= 1'b1;
                        u_state_reg    <= U_ACK;
                    end
                end
                U_ACK: begin
                    cache_ack_reg <= 1'b0;
                    u_state_reg   <= U_IDLE;
                end
                default: begin
                    cache_ack_reg <= 1'b0;
                    u_state_reg   <= U_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            d_state_reg    <= D_IDLE;
            mem_addr_reg   <= '0;
            mem_data_reg   <= '0;
            mem_enable_reg <= 1'b0;
            mem_write_reg  <= 1'b0;
        end else begin
            case (d_state_reg)
                D_IDLE: begin
                    if (start_read) begin
                        mem_addr_reg   <= {rd_tag_reg, 5'b0};
                        mem_write_reg  <= 1'b0;
                        mem_enable_reg <= 1'b1;
                        d_state_reg    <= D_READ;
                    end else if (start_write) begin
                        mem_addr_reg   <= {tag_reg[head_reg], 5'b0};
                        mem_data_reg   <= data_reg[head_reg];
                        mem_write_reg  <= 1'b1;
                        mem_enable_reg <= 1'b1;
                        d_state_reg    <= D_WRITE;
                    end
                end
                D_READ, D_WRITE: begin
                    if (mem_ack_i) begin
                        mem_enable_reg <= 1'b0;
                        mem_write_reg  <= 1'b0;
                        d_state_reg    <= D_IDLE;
                    end
                end
                default: begin
                    mem_enable_reg <= 1'b0;
                    d_state_reg    <= D_IDLE;
                end
            endcase
        end
    end

    assign cache_ack_o  = cache_ack_reg;
    assign cache_data_o = cache_data_reg;
    assign mem_addr_o   = mem_addr_reg;
    assign mem_data_o   = mem_data_reg;
    assign mem_enable_o = mem_enable_reg;
    assign mem_write_o  = mem_write_reg;
    assign wb_empty_o   = (count_reg == '0) && (d_state_reg != D_WRITE);

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer with a latency-configurable Data_Memory model.
module tb_dcache_write_buffer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [31:0]  cache_addr = '0;
    logic [255:0] cache_wdata = '0;
    logic         cache_enable = 1'b0;
    logic         cache_write = 1'b0;
    logic         cache_ack_o;
    logic [255:0] cache_data_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic         mem_ack = 1'b0;
    logic [255:0] mem_rdata = '0;
    logic         wb_empty_o;

    logic [255:0] mem_line [64];
    bit           log_wr   [256];
    logic [31:0]  log_addr [256];
    int           log_n = 0;
    int           mem_lat = 3;
    int           stale_cnt = 0;
    int           total = 0;
    int           bad = 0;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
        int           exp_lat;
    } vec_t;
    vec_t vecs [5];

    always #5 clk = ~clk;

    dcache_write_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .cache_addr_i(cache_addr), .cache_data_i(cache_wdata),
        .cache_enable_i(cache_enable), .cache_write_i(cache_write),
        .cache_ack_o(cache_ack_o), .cache_data_o(cache_data_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_ack_i(mem_ack), .mem_data_i(mem_rdata),
        .wb_empty_o(wb_empty_o)
    );

    // Memory model: acks after mem_lat sampled cycles of a held request.
    initial begin
        int cnt;
        int stale_done;
        int idx;
        cnt = 0;
        stale_done = 0;
        for (int i = 0; i < 64; i++) mem_line[i] = '0;
        mem_line[7] = 256'h5;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (stale_done != stale_cnt) begin
                stale_done = stale_cnt;
                mem_ack = 1'b1;
            end else if (mem_enable_o) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    cnt = 0;
                    idx = int'(mem_addr_o[10:5]);
                    if (mem_write_o) mem_line[idx] = mem_data_o;
                    else mem_rdata = mem_line[idx];
                    log_wr[log_n] = mem_write_o;
                    log_addr[log_n] = mem_addr_o;
                    log_n++;
                    mem_ack = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic cache_req(input bit wr, input logic [31:0] addr, input logic [255:0] data,
                             output logic [255:0] rdata, output int lat, output int log_at_ack);
        bit done;
        done = 1'b0;
        lat = 0;
        rdata = '0;
        log_at_ack = log_n;
        @(negedge clk);
        cache_enable = 1'b1;
        cache_write = wr;
        cache_addr = addr;
        cache_wdata = data;
        while (!done && lat < 500) begin
            @(posedge clk);
            #1;
            lat++;
            if (cache_ack_o) begin
                done = 1'b1;
                rdata = cache_data_o;
                log_at_ack = log_n;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL cache_ack_timeout: got no ack required ack for addr %h", addr);
        end
        @(negedge clk);
        cache_enable = 1'b0;
        $display("txn wr=%0d addr=%h lat=%0d rdata=%h", wr, addr, lat, rdata[31:0]);
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (!(wb_empty_o && !mem_enable_o) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (!(wb_empty_o && !mem_enable_o)) begin
            bad++;
            $display("FAIL %s: got busy after %0d cycles required drained", name, n);
        end
    endtask

    function automatic int count_reads(input int from);
        int r;
        r = 0;
        for (int i = from; i < log_n; i++) if (!log_wr[i]) r++;
        return r;
    endfunction

    initial begin
        logic [255:0] rd;
        int           lat;
        int           lack;
        int           s;
        int           n040;
        bit           seen_en;
        bit           seen_ack;

        for (int k = 0; k < 5; k++) begin
            vecs[k].wr      = 1'b1;
            vecs[k].addr    = 32'(k * 32);
            vecs[k].data    = {8{32'(32'h1000_0000 + k)}};
            vecs[k].exp_lat = (k < 4) ? 1 : 0;
        end

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cache_ack", cache_ack_o, 0);
        check("rst_mem_enable", mem_enable_o, 0);
        check("rst_mem_write", mem_write_o, 0);
        check("rst_cache_data", cache_data_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_mem_data", mem_data_o, 0);
        check("rst_wb_empty", wb_empty_o, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write-back drains to memory line 32.
        mem_lat = 3;
        cache_req(1'b1, 32'h400, {32{8'hAA}}, rd, lat, lack);
        check("wr_ack_lat", lat, 1);
        check("wr_not_empty", wb_empty_o, 0);
        @(posedge clk);
        #1;
        check("drain_enable", mem_enable_o, 1);
        check("drain_write", mem_write_o, 1);
        check("drain_addr", mem_addr_o, 32'h400);
        check("drain_data", mem_data_o, {32{8'hAA}});
        wait_empty("drain_a");
        check("mem32_aa", mem_line[32], {32{8'hAA}});
        check("empty_after", wb_empty_o, 1);

        // Forward a read from the queued write without touching memory.
        mem_lat = 10;
        s = log_n;
        cache_req(1'b1, 32'h400, {32{8'hCC}}, rd, lat, lack);
        cache_req(1'b0, 32'h400, '0, rd, lat, lack);
        check("fwd_data", rd, {32{8'hCC}});
        check("fwd_lat", lat, 1);
        wait_empty("drain_b");
        check("fwd_no_read", count_reads(s), 0);
        check("mem32_cc", mem_line[32], {32{8'hCC}});

        // Fill the buffer; the fifth write must wait for the first drain.
        s = log_n;
        for (int i = 0; i < 5; i++) begin
            cache_req(vecs[i].wr, vecs[i].addr, vecs[i].data, rd, lat, lack);
            if (vecs[i].exp_lat != 0) begin
                check($sformatf("fill_lat_%0d", i), lat, vecs[i].exp_lat);
            end else begin
                check("full_waits", lat > 1, 1);
                check("full_after_drain", lack > s, 1);
            end
        end
        wait_empty("drain_c");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("fill_mem_%0d", i), mem_line[i], vecs[i].data);
            check($sformatf("fill_order_%0d", i), {log_wr[s+i], log_addr[s+i]}, {1'b1, vecs[i].addr});
        end

        // Coalesce two writes to 0x040 behind an in-flight write to 0x100.
        s = log_n;
        cache_req(1'b1, 32'h100, 256'h77, rd, lat, lack);
        cache_req(1'b1, 32'h040, 256'h1, rd, lat, lack);
        cache_req(1'b1, 32'h040, 256'h2, rd, lat, lack);
        check("coal_lat", lat, 1);
        wait_empty("drain_d");
        n040 = 0;
        for (int i = s; i < log_n; i++) if (log_wr[i] && log_addr[i] == 32'h040) n040++;
        check("coal_one_write", n040, 1);
        check("coal_total_writes", log_n - s, 2);
        check("coal_mem", mem_line[2], 256'h2);

        // Read miss bypasses the second queued write.
        s = log_n;
        cache_req(1'b1, 32'h100, 256'hD1, rd, lat, lack);
        cache_req(1'b1, 32'h120, 256'hD2, rd, lat, lack);
        cache_req(1'b0, 32'h0EC, '0, rd, lat, lack);
        check("bypass_data", rd, 256'h5);
        wait_empty("drain_e");
        check("bypass_ops", log_n - s, 3);
        check("bypass_0", {log_wr[s], log_addr[s]}, {1'b1, 32'h100});
        check("bypass_1", {log_wr[s+1], log_addr[s+1]}, {1'b0, 32'h0E0});
        check("bypass_2", {log_wr[s+2], log_addr[s+2]}, {1'b1, 32'h120});
        check("bypass_mem9", mem_line[9], 256'hD2);

        // Asynchronous reset in the middle of a drain, then a stale ack.
        cache_req(1'b1, 32'h140, 256'hEE, rd, lat, lack);
        begin
            int n;
            n = 0;
            while (!mem_enable_o && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check("pre_rst_enable", mem_enable_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_enable", mem_enable_o, 0);
        check("arst_ack", cache_ack_o, 0);
        check("arst_empty", wb_empty_o, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale_cnt++;
        seen_en = 1'b0;
        seen_ack = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            seen_en |= mem_enable_o;
            seen_ack |= cache_ack_o;
        end
        check("stale_no_enable", seen_en, 0);
        check("stale_no_ack", seen_ack, 0);
        check("stale_empty", wb_empty_o, 1);
        check("aborted_not_written", mem_line[10], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1);
    end

endmodule
